// File: rtl/lfsr_step_sequencer.sv
// Single-clock enable sequencer for the LFSR core: free-run, hold, single-step, N-step burst, config reload.
// Edge on step/burst -> lfsr_en next cycle; bursts run to completion before config changes or hold are acted on.
module lfsr_step_sequencer #(
  parameter int BURST_W = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hold,
  input  logic               step,
  input  logic               burst,
  input  logic [BURST_W-1:0] burst_count,
  input  logic [3:0]         cfg_length,
  input  logic               cfg_n_taps,
  input  logic               lfsr_valid,
  output logic               lfsr_en,
  output logic               lfsr_reload,
  output logic [3:0]         length_q,
  output logic               n_taps_q,
  output logic               busy,
  output logic [CNT_W-1:0]   step_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_BURST,
    S_RELOAD
  } state_t;

  state_t               state_q, state_d;
  logic [BURST_W-1:0]   bcnt_q, bcnt_d;
  logic                 step_prev_q;
  logic                 burst_prev_q;
  logic                 step_edge;
  logic                 burst_edge;
  logic                 cfg_diff;

  assign step_edge  = step & ~step_prev_q;
  assign burst_edge = burst & ~burst_prev_q;
  assign cfg_diff   = (cfg_length != length_q) | (cfg_n_taps != n_taps_q);

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_diff) begin
          state_d = S_RELOAD;
        end else if (burst_edge && (burst_count != '0)) begin
          state_d = S_BURST;
          bcnt_d  = burst_count;
        end else if (step_edge) begin
          state_d = S_STEP;
        end else if (!hold) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (cfg_diff) begin
          state_d = S_RELOAD;
        end else if (hold) begin
          state_d = S_IDLE;
        end
      end
      S_STEP: begin
        state_d = S_IDLE;
      end
      // Everything else waits until the last burst enable has been issued.
      S_BURST: begin
        bcnt_d = bcnt_q - BURST_W'(1);
        if (bcnt_q == BURST_W'(1)) begin
          state_d = hold ? S_IDLE : S_RUN;
        end
      end
      S_RELOAD: begin
        state_d = hold ? S_IDLE : S_RUN;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      bcnt_q       <= '0;
      step_prev_q  <= 1'b0;
      burst_prev_q <= 1'b0;
      lfsr_en      <= 1'b0;
      lfsr_reload  <= 1'b0;
      busy         <= 1'b0;
      length_q     <= 4'd2;
      n_taps_q     <= 1'b0;
      step_count   <= '0;
    end else begin
      state_q      <= state_d;
      bcnt_q       <= bcnt_d;
      step_prev_q  <= step;
      burst_prev_q <= burst;
      lfsr_en      <= (state_d == S_RUN) || (state_d == S_STEP) || (state_d == S_BURST);
      lfsr_reload  <= (state_d == S_RELOAD);
      busy         <= (state_d == S_STEP) || (state_d == S_BURST) || (state_d == S_RELOAD);
      // Config latch and counter clear happen on the edge that enters RELOAD.
      if (state_d == S_RELOAD) begin
        length_q   <= cfg_length;
        n_taps_q   <= cfg_n_taps;
        step_count <= '0;
      end else if (lfsr_en && lfsr_valid) begin
        step_count <= step_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lfsr_step_sequencer.sv
// Bench for lfsr_step_sequencer: directed vector table, hand-written corner sequences,
// randomized stimulus against a behavioural model of enables owed / run mode.
`timescale 1ns/1ps
module tb_lfsr_step_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold, step, burst;
  logic [7:0]  burst_count;
  logic [3:0]  cfg_length;
  logic        cfg_n_taps;
  logic        lfsr_valid;
  logic        lfsr_en, lfsr_reload, n_taps_q, busy;
  logic [3:0]  length_q;
  logic [15:0] step_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lfsr_step_sequencer #(.BURST_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .step(step), .burst(burst),
    .burst_count(burst_count), .cfg_length(cfg_length), .cfg_n_taps(cfg_n_taps),
    .lfsr_valid(lfsr_valid), .lfsr_en(lfsr_en), .lfsr_reload(lfsr_reload),
    .length_q(length_q), .n_taps_q(n_taps_q), .busy(busy), .step_count(step_count)
  );

  // Reference model: enables still owed by a step/burst, and what mode follows it.
  bit m_en, m_rl, m_busy, m_run, m_follow, m_ps, m_pb;
  int m_owed;
  int m_len, m_taps, m_cnt;

  task automatic model_edge();
    bit se, be, diff;
    int n_cnt;
    se = step && !m_ps;
    be = burst && !m_pb;
    if (!rst_n) begin
      m_en = 0; m_rl = 0; m_busy = 0; m_run = 0; m_follow = 0; m_owed = 0;
      m_len = 2; m_taps = 0; m_cnt = 0; m_ps = 0; m_pb = 0;
      return;
    end
    diff  = (int'(cfg_length) != m_len) || (int'(cfg_n_taps) != m_taps);
    n_cnt = (m_en && lfsr_valid) ? (m_cnt + 1) % 65536 : m_cnt;
    if (m_owed > 0) begin
      m_owed = m_owed - 1;
    end else if (m_busy) begin
      m_run  = m_follow && !hold;
      m_en   = m_run;
      m_busy = 0;
      m_rl   = 0;
    end else if (diff) begin
      m_rl = 1; m_busy = 1; m_en = 0; m_run = 0; m_follow = 1;
      m_len = int'(cfg_length); m_taps = int'(cfg_n_taps);
      n_cnt = 0;
    end else if (m_run) begin
      if (hold) begin
        m_run = 0;
        m_en  = 0;
      end
    end else if (be && burst_count != 0) begin
      m_en = 1; m_busy = 1; m_follow = 1;
      m_owed = int'(burst_count) - 1;
    end else if (se) begin
      m_en = 1; m_busy = 1; m_follow = 0;
    end else if (!hold) begin
      m_run = 1;
      m_en  = 1;
    end
    m_cnt = n_cnt;
    m_ps  = step;
    m_pb  = burst;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input bit cmp);
    @(posedge clk);
    model_edge();
    #1;
    if (cmp) begin
      check("model_en",     32'(lfsr_en),     32'(m_en));
      check("model_reload", 32'(lfsr_reload), 32'(m_rl));
      check("model_busy",   32'(busy),        32'(m_busy));
      check("model_len",    32'(length_q),    32'(m_len));
      check("model_taps",   32'(n_taps_q),    32'(m_taps));
      check("model_cnt",    32'(step_count),  32'(m_cnt));
    end
  endtask

  typedef struct {
    logic       r, h, s, b;
    logic [7:0] bc;
    logic [3:0] len;
    logic       vl;
    logic       e_en, e_rl, e_busy;
    logic [3:0] e_len;
    logic [15:0] e_cnt;
  } vec_t;

  function automatic vec_t v(input logic r, h, s, b, input int bc, len, input logic vl,
                             input logic en, rl, bz, input int elen, ecnt);
    vec_t x;
    x.r = r; x.h = h; x.s = s; x.b = b; x.bc = 8'(bc); x.len = 4'(len); x.vl = vl;
    x.e_en = en; x.e_rl = rl; x.e_busy = bz; x.e_len = 4'(elen); x.e_cnt = 16'(ecnt);
    return x;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[32];
    int n;
    int bound;

    // rst hold step burst bc len valid | en reload busy len cnt
    vecs[0]  = v(0,0,0,0,0,0,0, 0,0,0,2,0);
    vecs[1]  = v(0,0,0,0,0,0,0, 0,0,0,2,0);
    vecs[2]  = v(0,1,0,0,0,2,1, 0,0,0,2,0);
    vecs[3]  = v(1,1,0,0,0,2,1, 0,0,0,2,0);
    vecs[4]  = v(1,1,1,0,0,2,1, 1,0,1,2,0);
    vecs[5]  = v(1,1,1,0,0,2,1, 0,0,0,2,1);
    vecs[6]  = v(1,1,1,0,0,2,1, 0,0,0,2,1);
    vecs[7]  = v(1,1,1,0,0,2,1, 0,0,0,2,1);
    vecs[8]  = v(1,1,1,0,0,2,1, 0,0,0,2,1);
    vecs[9]  = v(1,1,0,0,0,2,1, 0,0,0,2,1);
    vecs[10] = v(1,1,1,0,0,2,1, 1,0,1,2,1);
    vecs[11] = v(1,1,0,0,0,2,1, 0,0,0,2,2);
    vecs[12] = v(1,1,0,1,5,2,1, 1,0,1,2,2);
    vecs[13] = v(1,1,0,1,5,2,1, 1,0,1,2,3);
    vecs[14] = v(1,1,0,0,5,2,1, 1,0,1,2,4);
    vecs[15] = v(1,1,0,0,5,2,1, 1,0,1,2,5);
    vecs[16] = v(1,1,0,0,5,2,1, 1,0,1,2,6);
    vecs[17] = v(1,1,0,0,5,2,1, 0,0,0,2,7);
    vecs[18] = v(1,1,0,1,0,2,1, 0,0,0,2,7);
    vecs[19] = v(1,1,0,0,0,2,1, 0,0,0,2,7);
    vecs[20] = v(1,1,1,1,3,2,1, 1,0,1,2,7);
    vecs[21] = v(1,1,0,0,3,2,1, 1,0,1,2,8);
    vecs[22] = v(1,1,0,0,3,2,1, 1,0,1,2,9);
    vecs[23] = v(1,1,0,0,3,2,1, 0,0,0,2,10);
    vecs[24] = v(1,1,1,1,0,2,1, 1,0,1,2,10);
    vecs[25] = v(1,1,0,0,0,2,1, 0,0,0,2,11);
    vecs[26] = v(1,0,0,0,0,2,1, 1,0,0,2,11);
    vecs[27] = v(1,0,0,0,0,2,1, 1,0,0,2,12);
    vecs[28] = v(1,0,0,0,0,4,1, 0,1,1,4,0);
    vecs[29] = v(1,0,0,0,0,4,1, 1,0,0,4,0);
    vecs[30] = v(1,0,0,0,0,4,1, 1,0,0,4,1);
    vecs[31] = v(1,1,0,0,0,4,1, 0,0,0,4,2);

    rst_n = 0; hold = 0; step = 0; burst = 0; burst_count = 0;
    cfg_length = 0; cfg_n_taps = 0; lfsr_valid = 0;

    for (int i = 0; i < 32; i++) begin
      rst_n = vecs[i].r; hold = vecs[i].h; step = vecs[i].s; burst = vecs[i].b;
      burst_count = vecs[i].bc; cfg_length = vecs[i].len; lfsr_valid = vecs[i].vl;
      tick(1);
      check($sformatf("vec%0d_en", i),     32'(lfsr_en),     32'(vecs[i].e_en));
      check($sformatf("vec%0d_reload", i), 32'(lfsr_reload), 32'(vecs[i].e_rl));
      check($sformatf("vec%0d_busy", i),   32'(busy),        32'(vecs[i].e_busy));
      check($sformatf("vec%0d_len", i),    32'(length_q),    32'(vecs[i].e_len));
      check($sformatf("vec%0d_cnt", i),    32'(step_count),  32'(vecs[i].e_cnt));
    end

    // Config change during an 8-step burst: reload only after the last enable.
    burst_count = 8; burst = 1;
    tick(1);
    n = lfsr_en ? 1 : 0;
    burst = 0; cfg_length = 6;
    bound = 0;
    while (!lfsr_reload && bound < 30) begin
      tick(1);
      if (lfsr_en) n++;
      bound++;
    end
    check("midburst_reload_seen", 32'(lfsr_reload), 32'd1);
    check("midburst_enables", 32'(n), 32'd8);
    check("midburst_len", 32'(length_q), 32'd6);

    // Invalid config while free-running: enable continues, count frozen.
    hold = 0; cfg_length = 8; cfg_n_taps = 0; lfsr_valid = 0;
    for (int i = 0; i < 6; i++) tick(1);
    check("invalid_en", 32'(lfsr_en), 32'd1);
    check("invalid_cnt_frozen", 32'(step_count), 32'd0);

    // Reset in the middle of a 200-step burst.
    hold = 1; lfsr_valid = 1;
    tick(1); tick(1);
    burst_count = 200; burst = 1;
    tick(1);
    burst = 0;
    n = lfsr_en ? 1 : 0;
    bound = 0;
    while (n < 50 && bound < 100) begin
      tick(1);
      if (lfsr_en) n++;
      bound++;
    end
    check("rstburst_reached50", 32'(n), 32'd50);
    rst_n = 0;
    tick(1);
    check("rstburst_en", 32'(lfsr_en), 32'd0);
    check("rstburst_busy", 32'(busy), 32'd0);
    check("rstburst_cnt", 32'(step_count), 32'd0);
    cfg_length = 2; rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("rstburst_no_resume", 32'(lfsr_en | lfsr_reload), 32'd0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_n       = ($urandom_range(0, 199) != 0);
      hold        = ($urandom_range(0, 3) != 0);
      step        = 1'($urandom_range(0, 1));
      burst       = ($urandom_range(0, 3) == 0);
      burst_count = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
      lfsr_valid  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 29) == 0) begin
        cfg_length = 4'($urandom);
        cfg_n_taps = 1'($urandom);
      end
      tick(1);
    end

    // Counter wrap: free-run to 16'hFFFF, then one more step.
    rst_n = 0; hold = 0; step = 0; burst = 0; lfsr_valid = 1;
    cfg_length = 2; cfg_n_taps = 0;
    tick(1);
    rst_n = 1;
    bound = 0;
    while (m_cnt != 65535 && bound < 70000) begin
      tick(0);
      bound++;
    end
    check("wrap_preload", 32'(step_count), 32'hFFFF);
    check("wrap_running", 32'(lfsr_en), 32'd1);
    hold = 1;
    tick(1);
    check("wrap_to_zero", 32'(step_count), 32'd0);
    check("wrap_idle_en", 32'(lfsr_en), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
